svc_ice40_pll_ctrl: RTL and testbench

//   Sequencer for an iCE40 SB_PLL40 primitive, clocked by the PLL reference clock.
//   - Drives PLL RESETB and watches LOCK.
//   - Releases the downstream reset only after lock has been stable; retries on lock timeout.
//   - Flags permanent failure after MAX_RETRIES and re-sequences on sustained lock loss.
//   - Sits between the board oscillator/reset and any svc_ice40_pll_* instance.

---
 rtl/svc_ice40_pll_ctrl_pkg.sv | 37 +++
 rtl/svc_sync_2ff.sv | 24 ++
 rtl/svc_ice40_pll_ctrl.sv | 173 +++++++++++++++++
 tb/tb_svc_ice40_pll_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/svc_ice40_pll_ctrl_pkg.sv
// Shared types and constants for the iCE40 PLL sequencer.
package svc_ice40_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int RETRY_W = 8;
    localparam int LOL_W   = 16;

    // Saturating increment for the retry counter.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        logic [RETRY_W-1:0] r;
        if (v == {RETRY_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(RETRY_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Saturating increment for the lock-loss event counter.
    function automatic logic [LOL_W-1:0] lol_inc(input logic [LOL_W-1:0] v);
        logic [LOL_W-1:0] r;
        if (v == {LOL_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(LOL_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/svc_sync_2ff.sv
// Two-flop synchronizer, async active-low reset to 0.
module svc_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_r;

    // Capture the asynchronous input and pass it through a second stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_r <= {WIDTH{1'b0}};
            q_o    <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d_i;
            q_o    <= meta_r;
        end
    end

endmodule

// File: rtl/svc_ice40_pll_ctrl.sv
// Sequencer for an iCE40 SB_PLL40: drives RESETB, watches LOCK, releases the
// downstream reset once lock is stable, retries on timeout, flags failure.
// Optional feature macro: SVC_ICE40_PLL_CTRL_STATS_EN adds lol_count_o, a
// saturating count of RUN->RESET lock-loss events.
module svc_ice40_pll_ctrl
    import svc_ice40_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pll_lock_i,
    output logic               pll_resetb_o,
    output logic               ready_o,
    output logic               rst_out_no,
    output logic               fail_o,
`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
    output logic [LOL_W-1:0]   lol_count_o,
`endif
    output logic [RETRY_W-1:0] retries_o
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int GL_W  = $clog2(GLITCH_CYCLES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [GL_W-1:0]  GL_LAST  = GL_W'(GLITCH_CYCLES - 1);

    logic               lock_s;
    state_t             state_r, state_n;
    logic [RST_W-1:0]   rst_cnt_r, rst_cnt_n;
    logic [TO_W-1:0]    to_cnt_r, to_cnt_n;
    logic [SET_W-1:0]   settle_cnt_r, settle_cnt_n;
    logic [GL_W-1:0]    glitch_cnt_r, glitch_cnt_n;
    logic [RETRY_W-1:0] retries_r, retries_n;

    svc_sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    // Next-state and counter update; the WAIT_LOCK cycle that first sees
    // lock_s high already counts as the first of the settle window.
    always_comb begin
        state_n      = state_r;
        rst_cnt_n    = rst_cnt_r;
        to_cnt_n     = to_cnt_r;
        settle_cnt_n = settle_cnt_r;
        glitch_cnt_n = glitch_cnt_r;
        retries_n    = retries_r;
        case (state_r)
            RESET: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_n   = WAIT_LOCK;
                    rst_cnt_n = {RST_W{1'b0}};
                    to_cnt_n  = {TO_W{1'b0}};
                end else begin
                    rst_cnt_n = rst_cnt_r + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    if (SETTLE_CYCLES <= 1) begin
                        state_n      = RUN;
                        glitch_cnt_n = {GL_W{1'b0}};
                    end else begin
                        state_n      = SETTLE;
                        settle_cnt_n = SET_W'(1);
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    retries_n = retry_inc(retries_r);
                    to_cnt_n  = {TO_W{1'b0}};
                    rst_cnt_n = {RST_W{1'b0}};
                    if ((MAX_RETRIES != 0) && (int'(retries_n) >= MAX_RETRIES)) begin
                        state_n = FAIL;
                    end else begin
                        state_n = RESET;
                    end
                end else begin
                    to_cnt_n = to_cnt_r + TO_W'(1);
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_n  = WAIT_LOCK;
                    to_cnt_n = {TO_W{1'b0}};
                end else if (settle_cnt_r == SET_LAST) begin
                    state_n      = RUN;
                    glitch_cnt_n = {GL_W{1'b0}};
                end else begin
                    settle_cnt_n = settle_cnt_r + SET_W'(1);
                end
            end
            RUN: begin
                if (lock_s) begin
                    glitch_cnt_n = {GL_W{1'b0}};
                end else if (glitch_cnt_r == GL_LAST) begin
                    state_n      = RESET;
                    rst_cnt_n    = {RST_W{1'b0}};
                    glitch_cnt_n = {GL_W{1'b0}};
                end else begin
                    glitch_cnt_n = glitch_cnt_r + GL_W'(1);
                end
            end
            FAIL: begin
                state_n = FAIL;
            end
            default: begin
                state_n = RESET;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= RESET;
            rst_cnt_r    <= {RST_W{1'b0}};
            to_cnt_r     <= {TO_W{1'b0}};
            settle_cnt_r <= {SET_W{1'b0}};
            glitch_cnt_r <= {GL_W{1'b0}};
            retries_r    <= {RETRY_W{1'b0}};
            pll_resetb_o <= 1'b0;
            ready_o      <= 1'b0;
            rst_out_no   <= 1'b0;
            fail_o       <= 1'b0;
        end else begin
            state_r      <= state_n;
            rst_cnt_r    <= rst_cnt_n;
            to_cnt_r     <= to_cnt_n;
            settle_cnt_r <= settle_cnt_n;
            glitch_cnt_r <= glitch_cnt_n;
            retries_r    <= retries_n;
            pll_resetb_o <= (state_n == WAIT_LOCK) || (state_n == SETTLE) || (state_n == RUN);
            ready_o      <= (state_n == RUN);
            rst_out_no   <= (state_n == RUN);
            fail_o       <= (state_n == FAIL);
        end
    end

    assign retries_o = retries_r;

`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
    logic             lol_event_s;
    logic [LOL_W-1:0] lol_cnt_r;

    assign lol_event_s = (state_r == RUN) && (state_n == RESET);

    // Count lock-loss re-sequences, saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lol_cnt_r <= {LOL_W{1'b0}};
        end else if (lol_event_s) begin
            lol_cnt_r <= lol_inc(lol_cnt_r);
        end else begin
            lol_cnt_r <= lol_cnt_r;
        end
    end

    assign lol_count_o = lol_cnt_r;
`endif

endmodule

// File: tb/tb_svc_ice40_pll_ctrl.sv
// Directed self-checking bench for svc_ice40_pll_ctrl.
module tb_svc_ice40_pll_ctrl;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       pll_resetb;
    logic       ready;
    logic       rst_out_n;
    logic       fail;
    logic [7:0] retries;

    logic       rst2_n;
    logic       lock2;
    logic       pll_resetb2;
    logic       ready2;
    logic       rst_out2_n;
    logic       fail2;
    logic [7:0] retries2;

`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
    logic [15:0] lol_count;
    logic [15:0] lol_count2;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    svc_ice40_pll_ctrl #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(32), .SETTLE_CYCLES(8),
        .GLITCH_CYCLES(2), .MAX_RETRIES(3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_lock_i   (lock),
        .pll_resetb_o (pll_resetb),
        .ready_o      (ready),
        .rst_out_no   (rst_out_n),
        .fail_o       (fail),
`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
        .lol_count_o  (lol_count),
`endif
        .retries_o    (retries)
    );

    svc_ice40_pll_ctrl #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(32), .SETTLE_CYCLES(8),
        .GLITCH_CYCLES(2), .MAX_RETRIES(0)
    ) dut_inf (
        .clk_i        (clk),
        .rst_ni       (rst2_n),
        .pll_lock_i   (lock2),
        .pll_resetb_o (pll_resetb2),
        .ready_o      (ready2),
        .rst_out_no   (rst_out2_n),
        .fail_o       (fail2),
`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
        .lol_count_o  (lol_count2),
`endif
        .retries_o    (retries2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        lock   = 1'b0;
        lock2  = 1'b0;
        step(2);
        check("rst_resetb",  {15'd0, pll_resetb}, 16'd0);
        check("rst_ready",   {15'd0, ready},      16'd0);
        check("rst_rstout",  {15'd0, rst_out_n},  16'd0);
        check("rst_fail",    {15'd0, fail},       16'd0);
        check("rst_retries", {8'd0, retries},     16'd0);

        // 1: lock 5 cycles after RESETB release, ready 10 edges after lock rises
        rst_n = 1'b1;
        step(3);
        check("t1_resetb_held", {15'd0, pll_resetb}, 16'd0);
        step(1);
        check("t1_resetb_rel",  {15'd0, pll_resetb}, 16'd1);
        step(5);
        lock = 1'b1;
        step(9);
        check("t1_ready_early",  {15'd0, ready},     16'd0);
        check("t1_rstout_early", {15'd0, rst_out_n}, 16'd0);
        step(1);
        check("t1_ready",   {15'd0, ready},     16'd1);
        check("t1_rstout",  {15'd0, rst_out_n}, 16'd1);
        check("t1_retries", {8'd0, retries},    16'd0);

        // 4: single-cycle glitch tolerated, two-cycle loss re-sequences
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t4_glitch1_ready", {15'd0, ready}, 16'd1);
        end
        lock = 1'b0;
        step(2);
        lock = 1'b1;
        step(1);
        check("t4_ready_before", {15'd0, ready}, 16'd1);
        step(1);
        check("t4_ready_drop",   {15'd0, ready},      16'd0);
        check("t4_rstout_drop",  {15'd0, rst_out_n},  16'd0);
        check("t4_resetb_low",   {15'd0, pll_resetb}, 16'd0);
        check("t4_retries",      {8'd0, retries},     16'd0);
`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
        check("t4_lol_count", lol_count, 16'd1);
`endif
        step(3);
        check("t4_resetb_low4",  {15'd0, pll_resetb}, 16'd0);
        step(1);
        check("t4_resetb_rel",   {15'd0, pll_resetb}, 16'd1);
        step(7);
        check("t4_ready_relock_early", {15'd0, ready}, 16'd0);
        step(1);
        check("t4_ready_relock", {15'd0, ready}, 16'd1);

        // 5a: async reset in RUN
        rst_n = 1'b0;
        #1;
        check("t5r_ready",   {15'd0, ready},      16'd0);
        check("t5r_rstout",  {15'd0, rst_out_n},  16'd0);
        check("t5r_resetb",  {15'd0, pll_resetb}, 16'd0);
        check("t5r_fail",    {15'd0, fail},       16'd0);
        check("t5r_retries", {8'd0, retries},     16'd0);
`ifdef SVC_ICE40_PLL_CTRL_STATS_EN
        check("t5r_lol_count", lol_count, 16'd0);
`endif
        lock = 1'b0;
        step(1);
        rst_n = 1'b1;

        // 3: lock drop inside SETTLE restarts the 8-cycle window
        step(4);
        check("t3_resetb_rel", {15'd0, pll_resetb}, 16'd1);
        lock = 1'b1;
        step(5);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(9);
        check("t3_ready_early", {15'd0, ready}, 16'd0);
        step(1);
        check("t3_ready", {15'd0, ready}, 16'd1);

        // 5b: async reset in SETTLE
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(7);
        check("t5s_resetb_pre", {15'd0, pll_resetb}, 16'd1);
        check("t5s_ready_pre",  {15'd0, ready},      16'd0);
        rst_n = 1'b0;
        #1;
        check("t5s_resetb", {15'd0, pll_resetb}, 16'd0);
        check("t5s_ready",  {15'd0, ready},      16'd0);
        check("t5s_rstout", {15'd0, rst_out_n},  16'd0);

        // 2: lock never rises -> three timeouts then FAIL
        lock = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(35);
        check("t2_resetb_wait",  {15'd0, pll_resetb}, 16'd1);
        check("t2_retries0",     {8'd0, retries},     16'd0);
        step(1);
        check("t2_resetb_retry", {15'd0, pll_resetb}, 16'd0);
        check("t2_retries1",     {8'd0, retries},     16'd1);
        check("t2_fail_early",   {15'd0, fail},       16'd0);
        step(3);
        check("t2_resetb_pulse", {15'd0, pll_resetb}, 16'd0);
        step(1);
        check("t2_resetb_rel2",  {15'd0, pll_resetb}, 16'd1);
        step(67);
        check("t2_fail_before",  {15'd0, fail},       16'd0);
        check("t2_retries2",     {8'd0, retries},     16'd2);
        step(1);
        check("t2_fail",         {15'd0, fail},       16'd1);
        check("t2_retries3",     {8'd0, retries},     16'd3);
        check("t2_resetb_fail",  {15'd0, pll_resetb}, 16'd0);
        check("t2_ready_fail",   {15'd0, ready},      16'd0);
        step(50);
        check("t2_fail_sticky",  {15'd0, fail},       16'd1);
        check("t2_resetb_hold",  {15'd0, pll_resetb}, 16'd0);
        check("t2_retries_hold", {8'd0, retries},     16'd3);

        // 6: MAX_RETRIES=0 retries forever, counter saturates
        rst2_n = 1'b1;
        step(361);
        check("t6_retries10", {8'd0, retries2}, 16'd10);
        check("t6_fail10",    {15'd0, fail2},   16'd0);
        step(36 * 300);
        check("t6_retries_sat", {8'd0, retries2}, 16'd255);
        check("t6_fail_sat",    {15'd0, fail2},   16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
